// File: rtl/wbm_spi_cmd_pkg.sv
// Shared definitions for the SPI-to-Wishbone command engine: command bytes,
// FSM state encoding and small byte-selection helpers.
package wbm_spi_cmd_pkg;

  // Command opcodes carried in the first byte of a frame
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  // Number of data bytes in a write payload / read response
  localparam logic [2:0] WORD_BYTES = 3'd4;

  // Command engine states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for a command byte
    ST_ADDR  = 3'd1,  // waiting for the word address byte
    ST_WDATA = 3'd2,  // collecting four write-data bytes, MSB first
    ST_WB    = 3'd3,  // Wishbone classic cycle in progress
    ST_TX    = 3'd4   // exporting four read-data bytes, MSB first
  } state_t;

  // True for the two recognised command opcodes
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

  // Byte idx of a word, counting from the most significant byte
  function automatic logic [7:0] word_byte(input logic [31:0] w,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wbm_spi_cmd_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs entering the Wishbone clock
// domain. Each bit is synchronised independently, so multi-bit use is only
// valid for bits that are independent of one another.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage resynchronisation, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wbm_spi_cmd.sv
// Wishbone-side command engine of the SPI-to-Wishbone bridge.
//
// Byte transport in both directions uses a two-phase toggle handshake: the
// producer places a byte on *_data and then inverts *_req; a transfer is
// pending while req != ack; the consumer takes the byte and copies req into
// ack to complete it. The producer must keep *_data stable while a transfer
// is pending and may not start another one until req == ack again.
//
// Incoming frames are: command ('W' or 'R'), word address, then four data
// bytes MSB first for writes. Each frame becomes a single Wishbone B4
// classic cycle; read results are returned as four bytes, MSB first.
module wbm_spi_cmd
  import wbm_spi_cmd_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_csn,
  input  logic        rx_handshake_req,
  input  logic [7:0]  rx_handshake_data,
  output logic        rx_handshake_ack,
  output logic        tx_handshake_req,
  output logic [7:0]  tx_handshake_data,
  input  logic        tx_handshake_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [2:0]  dbg_state
);

  // ---------------------------------------------------------------------
  // Synchronisers for the asynchronous SPI-side signals
  // ---------------------------------------------------------------------
  logic rx_req_s;
  logic tx_ack_s;
  logic csn_s;

  sync_2ff #(.W(1)) u_sync_rx_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_handshake_req),
    .q     (rx_req_s)
  );

  sync_2ff #(.W(1)) u_sync_tx_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_handshake_ack),
    .q     (tx_ack_s)
  );

  sync_2ff #(.W(1)) u_sync_csn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_csn),
    .q     (csn_s)
  );

  // ---------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------
  state_t      state;
  state_t      next_state;

  logic        rx_ack;      // ack toggle returned to the RX stage
  logic        rx_vld;      // one-cycle pulse: rx_byte holds a fresh byte
  logic [7:0]  rx_byte;     // last byte taken from the RX stage
  logic        csn_q;       // previous synced chip select, for edge detect

  logic        we_q;        // current frame is a write
  logic [2:0]  cnt;         // byte counter for WDATA and TX
  logic [7:0]  tmo_cnt;     // cycles spent waiting for wb_ack_i
  logic [31:0] rd_data;     // read result (or all-ones after timeout)
  logic        tx_req;      // req toggle towards the TX stage
  logic [7:0]  tx_data;     // byte presented to the TX stage

  logic        rx_event;
  logic        csn_rise;
  logic        wb_timeout;
  logic        tx_free;
  logic        tx_load;

  assign rx_event   = (rx_req_s != rx_ack);
  assign csn_rise   = csn_s & ~csn_q;
  assign wb_timeout = (tmo_cnt == TIMEOUT);
  assign tx_free    = (tx_ack_s == tx_req);
  assign tx_load    = (state == ST_TX) && tx_free && (cnt != WORD_BYTES);

  assign rx_handshake_ack  = rx_ack;
  assign tx_handshake_req  = tx_req;
  assign tx_handshake_data = tx_data;
  assign wb_sel_o          = 4'hF;

  // ---------------------------------------------------------------------
  // RX intake: acknowledge every byte event the cycle it is seen, in any
  // state; the FSM decides one cycle later whether the byte is used.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ack  <= 1'b0;
      rx_vld  <= 1'b0;
      rx_byte <= 8'h00;
      csn_q   <= 1'b0;
    end else begin
      rx_vld <= rx_event;
      csn_q  <= csn_s;
      if (rx_event) begin
        rx_ack  <= rx_req_s;
        rx_byte <= rx_handshake_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic; a chip-select rise ends an unfinished frame but
  // never cancels a cycle that the same byte has just launched
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rx_vld && is_cmd(rx_byte)) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (rx_vld) next_state = we_q ? ST_WDATA : ST_WB;
      end
      ST_WDATA: begin
        if (rx_vld && (cnt == WORD_BYTES - 3'd1)) next_state = ST_WB;
      end
      ST_WB: begin
        if (wb_ack_i || wb_timeout) next_state = we_q ? ST_IDLE : ST_TX;
      end
      ST_TX: begin
        if ((cnt == WORD_BYTES) && tx_free) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    if (csn_rise &&
        ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_WDATA)) &&
        (next_state != ST_WB)) begin
      next_state = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // FSM outputs: bus strobes follow the state directly so that a reset
  // drops them without waiting for a clock
  // ---------------------------------------------------------------------
  always_comb begin
    wb_cyc_o  = (state == ST_WB);
    wb_stb_o  = (state == ST_WB);
    wb_we_o   = (state == ST_WB) && we_q;
    dbg_state = state;
  end

  // ---------------------------------------------------------------------
  // Datapath: frame parsing, bus cycle bookkeeping and response export
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      wb_adr_o <= 8'h00;
      wb_dat_o <= 32'h0000_0000;
      cnt      <= 3'd0;
      tmo_cnt  <= 8'h00;
      rd_data  <= 32'h0000_0000;
      tx_req   <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_vld && is_cmd(rx_byte)) we_q <= (rx_byte == CMD_WRITE);
        end
        ST_ADDR: begin
          if (rx_vld) begin
            wb_adr_o <= rx_byte;
            cnt      <= 3'd0;
          end
        end
        ST_WDATA: begin
          if (rx_vld) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_byte};
            cnt      <= cnt + 3'd1;
          end
        end
        ST_WB: begin
          if (wb_ack_i) begin
            if (!we_q) rd_data <= wb_dat_i;
            cnt     <= 3'd0;
            tmo_cnt <= 8'h00;
          end else if (wb_timeout) begin
            if (!we_q) rd_data <= 32'hFFFF_FFFF;
            cnt     <= 3'd0;
            tmo_cnt <= 8'h00;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h01;
          end
        end
        ST_TX: begin
          if (tx_load) begin
            tx_data <= word_byte(rd_data, cnt[1:0]);
            tx_req  <= ~tx_req;
            cnt     <= cnt + 3'd1;
          end
        end
        default: begin
          cnt     <= 3'd0;
          tmo_cnt <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_spi_cmd.sv
// Directed testbench for wbm_spi_cmd: drives SPI-side bytes over the toggle
// handshake, models a Wishbone slave and the SPI TX stage, and scores bus
// cycles and exported bytes against hand-computed expectations.
module tb_wbm_spi_cmd;
  import wbm_spi_cmd_pkg::*;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_csn;
  logic        rx_handshake_req;
  logic [7:0]  rx_handshake_data;
  logic        rx_handshake_ack;
  logic        tx_handshake_req;
  logic [7:0]  tx_handshake_data;
  logic        tx_handshake_ack;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  wbm_spi_cmd #(.TIMEOUT(8'd255)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .spi_csn           (spi_csn),
    .rx_handshake_req  (rx_handshake_req),
    .rx_handshake_data (rx_handshake_data),
    .rx_handshake_ack  (rx_handshake_ack),
    .tx_handshake_req  (tx_handshake_req),
    .tx_handshake_data (tx_handshake_data),
    .tx_handshake_ack  (tx_handshake_ack),
    .wb_cyc_o          (wb_cyc_o),
    .wb_stb_o          (wb_stb_o),
    .wb_we_o           (wb_we_o),
    .wb_adr_o          (wb_adr_o),
    .wb_dat_o          (wb_dat_o),
    .wb_sel_o          (wb_sel_o),
    .wb_dat_i          (wb_dat_i),
    .wb_ack_i          (wb_ack_i),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  // Expected bus cycles: {sel, we, adr, dat (0 for reads)}
  logic [44:0] exp_wb_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  frame_q[$];

  // Slave model controls and observations
  logic        slave_en    = 1'b1;
  int          slave_lat   = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          cyc_count   = 0;
  int          cur_len     = 0;
  int          last_len    = 0;
  logic        cyc_prev    = 1'b0;
  int          wait_cnt    = 0;

  // TX stage model
  logic        tx_ack_r    = 1'b0;
  int          tx_toggles  = 0;
  int          tx_wait     = 0;

  int          lat;
  int          base_cyc;
  int          base_tx;

  assign tx_handshake_ack = tx_ack_r;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Wishbone slave: acks after slave_lat waiting cycles, scores each cycle
  // at the moment it acks; also measures how long cyc stays high
  // ---------------------------------------------------------------------
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o) begin
        if (!cyc_prev) cur_len = 0;
        cur_len++;
      end else if (cyc_prev) begin
        last_len = cur_len;
        cyc_count++;
      end
      cyc_prev = wb_cyc_o;

      if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        wait_cnt = 0;
      end else if (wb_cyc_o && wb_stb_o && slave_en) begin
        if (wait_cnt == slave_lat) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slave_rdata;
          check("wb_q_nonempty", exp_wb_q.size() != 0, 1);
          if (exp_wb_q.size() != 0)
            check("wb_txn", {wb_sel_o, wb_we_o, wb_adr_o,
                             (wb_we_o ? wb_dat_o : 32'h0)},
                  exp_wb_q.pop_front());
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // SPI TX stage: takes each offered byte two cycles after seeing it
  // ---------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_handshake_req != tx_ack_r) begin
        if (tx_wait == 2) begin
          check("tx_q_nonempty", exp_tx_q.size() != 0, 1);
          if (exp_tx_q.size() != 0)
            check("tx_byte", tx_handshake_data, exp_tx_q.pop_front());
          tx_toggles++;
          tx_ack_r = tx_handshake_req;
          tx_wait  = 0;
        end else begin
          tx_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One RX byte; returns clocks from req toggle to ack toggle
  task automatic send_byte(input logic [7:0] b, output int l);
    rx_handshake_data = b;
    rx_handshake_req  = ~rx_handshake_req;
    l = 0;
    while ((rx_handshake_ack != rx_handshake_req) && (l < 20)) begin
      @(negedge clk);
      l++;
    end
    if (rx_handshake_ack != rx_handshake_req)
      check("rx_ack_timeout", rx_handshake_ack, rx_handshake_req);
  endtask

  // Sends every byte in frame_q, checking the ack latency of each
  task automatic send_frame();
    int l;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], l);
      check("rx_latency", l, 3);
    end
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while ((tx_toggles < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("tx_count", tx_toggles, target);
  endtask

  // Bound on the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst_n             = 1'b0;
    spi_csn           = 1'b1;
    rx_handshake_req  = 1'b0;
    rx_handshake_data = 8'h00;
    wait_cycles(3);

    // Reset state
    check("rst_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_adr", wb_adr_o, 8'h00);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_hs", {rx_handshake_ack, tx_handshake_req}, 2'b00);
    check("rst_txd", tx_handshake_data, 8'h00);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_sel", wb_sel_o, 4'hF);
    rst_n = 1'b1;
    wait_cycles(4);

    // Write 0xDEADBEEF to 0x10
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc  = cyc_count;
    base_tx   = tx_toggles;
    slave_lat = 2;
    exp_wb_q.push_back({4'hF, 1'b1, 8'h10, 32'hDEADBEEF});
    frame_q = {8'h57, 8'h10, 8'hDE, 8'hAD, 8'hBE};
    send_frame();
    send_byte(8'hEF, lat);
    check("rx_latency", lat, 3);
    check("wb_entry_pre", wb_cyc_o, 1'b0);
    @(negedge clk);
    check("wb_entry", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    wait_cycles(10);
    check("wr_cycles", cyc_count - base_cyc, 1);
    check("wr_no_tx", tx_toggles - base_tx, 0);
    check("wr_idle", dbg_state, ST_IDLE);
    spi_csn = 1'b1;
    wait_cycles(4);

    // Read 0x20, slave answers 0x12345678 after 3 wait cycles
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc    = cyc_count;
    base_tx     = tx_toggles;
    slave_lat   = 3;
    slave_rdata = 32'h1234_5678;
    exp_wb_q.push_back({4'hF, 1'b0, 8'h20, 32'h0});
    exp_tx_q.push_back(8'h12);
    exp_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h56);
    exp_tx_q.push_back(8'h78);
    frame_q = {8'h52, 8'h20};
    send_frame();
    wait_tx(base_tx + 4, 200);
    wait_cycles(8);
    check("rd_toggles", tx_toggles - base_tx, 4);
    check("rd_cycles", cyc_count - base_cyc, 1);
    check("rd_idle", dbg_state, ST_IDLE);
    spi_csn = 1'b1;
    wait_cycles(4);

    // Read 0x30 with no slave response: timeout and all-ones result
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc = cyc_count;
    base_tx  = tx_toggles;
    slave_en = 1'b0;
    repeat (4) exp_tx_q.push_back(8'hFF);
    frame_q = {8'h52, 8'h30};
    send_frame();
    wait_tx(base_tx + 4, 600);
    wait_cycles(8);
    check("tmo_len", last_len, 256);
    check("tmo_cycles", cyc_count - base_cyc, 1);
    check("tmo_idle", dbg_state, ST_IDLE);
    slave_en = 1'b1;
    spi_csn  = 1'b1;
    wait_cycles(4);

    // Bad command byte is ignored, following write runs normally
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc  = cyc_count;
    slave_lat = 0;
    exp_wb_q.push_back({4'hF, 1'b1, 8'h01, 32'h0000_0001});
    send_byte(8'h00, lat);
    check("rx_latency", lat, 3);
    wait_cycles(2);
    check("bad_cmd_idle", dbg_state, ST_IDLE);
    frame_q = {8'h57, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame();
    wait_cycles(12);
    check("bad_cmd_cycles", cyc_count - base_cyc, 1);
    spi_csn = 1'b1;
    wait_cycles(4);

    // Frame cut short by chip select: no bus cycle
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc = cyc_count;
    frame_q = {8'h57, 8'h05, 8'hAA};
    send_frame();
    wait_cycles(2);
    check("abort_wdata", dbg_state, ST_WDATA);
    spi_csn = 1'b1;
    wait_cycles(6);
    check("abort_idle", dbg_state, ST_IDLE);
    check("abort_cycles", cyc_count - base_cyc, 0);

    // Next frame after the abort reads normally
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc    = cyc_count;
    base_tx     = tx_toggles;
    slave_lat   = 1;
    slave_rdata = 32'hA55A_0FF0;
    exp_wb_q.push_back({4'hF, 1'b0, 8'h05, 32'h0});
    exp_tx_q.push_back(8'hA5);
    exp_tx_q.push_back(8'h5A);
    exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'hF0);
    frame_q = {8'h52, 8'h05};
    send_frame();
    wait_tx(base_tx + 4, 200);
    wait_cycles(8);
    check("post_abort_cycles", cyc_count - base_cyc, 1);
    spi_csn = 1'b1;
    wait_cycles(4);

    // Filler bytes during a slow read are acked and dropped
    spi_csn = 1'b0;
    wait_cycles(3);
    base_cyc    = cyc_count;
    base_tx     = tx_toggles;
    slave_lat   = 20;
    slave_rdata = 32'hCAFE_F00D;
    exp_wb_q.push_back({4'hF, 1'b0, 8'h40, 32'h0});
    exp_tx_q.push_back(8'hCA);
    exp_tx_q.push_back(8'hFE);
    exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'h0D);
    frame_q = {8'h52, 8'h40};
    send_frame();
    frame_q = {8'h11, 8'h22, 8'h33};
    send_frame();
    check("filler_in_wb", dbg_state, ST_WB);
    wait_tx(base_tx + 4, 300);
    wait_cycles(8);
    check("filler_cycles", cyc_count - base_cyc, 1);
    check("filler_idle", dbg_state, ST_IDLE);
    spi_csn = 1'b1;
    wait_cycles(4);

    // Everything expected was observed
    check("wb_q_drained", exp_wb_q.size(), 0);
    check("tx_q_drained", exp_tx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wbm_spi_cmd.md
# wbm_spi_cmd

Wishbone-domain command engine of the SPI-to-Wishbone bridge. Imports bytes produced by the SPI receive stage over its two-phase req/ack handshake. Parses them into single 32-bit read or write transactions, runs each as a Wishbone B4 classic master cycle, and exports read data bytes to the SPI transmit stage over the same handshake style. Sits between the SPI RX/TX clock-domain stages and the system Wishbone bus.

## Interface
- TIMEOUT, 255: Wishbone cycles to wait for `wb_ack_i` before abandoning a cycle; width 8 bits, value ≥ 1.
- clk  in  1  Wishbone/system clock; clock and reset are one domain.
- rst_n  in  1  asynchronous active-low reset.
- spi_csn  in  1  raw SPI chip select (async); synchronised internally.
- rx_handshake_req  in  1  toggle from SPI RX stage (async).
- rx_handshake_data  in  8  byte from SPI RX; stable while req ≠ ack.
- rx_handshake_ack  out  1  toggle back to SPI RX stage.
- tx_handshake_req  out  1  toggle to SPI TX stage.
- tx_handshake_data  out  8  byte to SPI TX; held stable while req ≠ synced ack.
- tx_handshake_ack  in  1  toggle from SPI TX stage (async).
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls.
- wb_adr_o  out  8  word address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  cycle acknowledge.

## Operation
- Two-flop synchronisers on `rx_handshake_req`, `tx_handshake_ack`, `spi_csn`.
- RX byte event: synced rx req ≠ `rx_handshake_ack`.
  - Every event is acknowledged the cycle it is detected: capture data, set ack = synced req.
  - Acknowledgement happens in all states; the byte is consumed or discarded according to state.
- Frame: command, address, then 4 data bytes for writes, MSB first.
  - 0x57 ('W') = write; 0x52 ('R') = read.
  - Any other command byte is discarded; FSM stays in IDLE.
- FSM states:
  - IDLE: command byte → ADDR, latch `we`.
  - ADDR: byte → `wb_adr_o`; write → WDATA with cnt=0; read → WB.
  - WDATA: shift byte into `wb_dat_o` from the low end, cnt+1; after 4th byte → WB.
  - WB: cyc=stb=1.
    - On `wb_ack_i`: drop cyc/stb next edge; latch `wb_dat_i` if read; read → TX cnt=0, write → IDLE.
    - On timeout counter reaching TIMEOUT with no ack: drop cyc/stb; read latches 0xFFFFFFFF → TX; write → IDLE.
  - TX: if synced tx ack == tx req, load `tx_handshake_data` = byte cnt (MSB first), toggle req, cnt+1. After the 4th byte is acknowledged → IDLE.
- Bytes arriving in WB or TX are dummy/filler: acknowledged and discarded.
- Synced `spi_csn` rising edge (end of frame):
  - IDLE/ADDR/WDATA → IDLE; partial data discarded, no bus cycle.
  - WB: cycle completes normally, result still exported.
  - TX: remaining bytes still exported.

## Timing
- Reset values:
  - all handshake outputs 0;
  - wb_cyc_o, wb_stb_o, wb_we_o 0; wb_adr_o 0; wb_dat_o 0; tx_handshake_data 0;
  - FSM IDLE, counters 0.
- RX latency: req toggle → ack toggle = 2 sync cycles + 1 register cycle (3 clk).
- WB entry: `wb_cyc_o` rises 1 clk after the final frame byte is captured.
- Ack handling: `wb_ack_i` sampled at posedge; cyc low on the following cycle; minimum cycle length 1 clk with ack.
- Timeout count starts at 0 on cycle entry; abort at count == TIMEOUT, i.e. TIMEOUT+1 cycles with cyc high.
- TX: one toggle per byte, next byte only after synced ack matches; first tx toggle 1 clk after WB exit.
- Simultaneous csn rise and byte event: byte is processed first under the current state, then the FSM resets to IDLE the same edge. Final write-data byte plus csn rise still launches the cycle.
- Reset mid-cycle: cyc/stb drop asynchronously; toggles return to 0.

## Structure
- Shared package/include: command constants CMD_WRITE=8'h57, CMD_READ=8'h52; FSM state encodings.
- Sub-module: `sync_2ff` (parameterised width, async active-low reset), instanced three times.

## Test plan
- Write: bytes 57,10,DE,AD,BE,EF → one cycle adr=0x10, we=1, dat=0xDEADBEEF, sel=F; no tx toggles.
- Read: bytes 52,20; slave returns 0x12345678 after 3 cycles → tx bytes 12,34,56,78 in order, 4 toggles.
- Timeout: read adr 0x30, slave never acks → cyc high exactly 256 clk; tx bytes FF,FF,FF,FF.
- Bad command 0x00 then 57,01,00,00,00,01 → only one write, adr=0x01, dat=0x00000001.
- Abort: 57,05,AA then csn rises → no bus cycle; next frame 52,05 reads normally.
- Filler: 3 dummy bytes during WB of a read → all acked within 3 clk each, tx output unaffected.
